ps2_note_key_decoder: RTL and testbench
=======================================

// Module: ps2_note_key_decoder
// PURPOSE
//  - Converts the PS/2 keyboard scan-code byte stream into the 7-bit ASCII key
//    value that drives the note/sharp seven-segment display decoder.
//  - Tracks make/break (F0) and extended (E0) prefixes.
//  - Holds the ASCII of the currently pressed piano key and flags press/release events.
//  - Sits between the PS/2 byte receiver and the display/recorder logic.
// PARAMETERS
//  - RELEASE_TIMEOUT  default 25_000_000  cycles without any byte before a held key is
//    force-released. Used only with AUTO_RELEASE_EN.
// PORTS
//  - clk            in   1  system clock; the only clock
//  - reset          in   1  asynchronous, active-high reset
//  - ps2_byte       in   8  received scan-code byte
//  - ps2_byte_valid in   1  1-cycle strobe; ps2_byte is valid this cycle
//  - ascii_val      out  7  ASCII of the held key; 7'h7F when no key is held (blank display)
//  - key_held       out  1  high while a mapped key is held
//  - key_press      out  1  1-cycle pulse when a new key is accepted
//  - key_release    out  1  1-cycle pulse when the held key is released
// BEHAVIOUR
//  - Reset values: ascii_val=7'h7F, key_held=0, key_press=0, key_release=0, state=IDLE,
//    timeout counter=0.
//  - All outputs are registered.
//    * A byte strobed in cycle N updates outputs at the cycle N+1 edge.
//    * Pulses are high for exactly one cycle.
//    * A valid strobe is accepted every cycle, including back-to-back.
//  - Key map (make code -> ASCII):
//      1C->65 A   1D->87 W   1B->83 S   24->69 E   23->68 D   2B->70 F
//      2C->84 T   34->71 G   35->89 Y   33->72 H   3C->85 U   3B->74 J
//  - FSM, advanced only on ps2_byte_valid:
//    * IDLE:
//      - F0 -> BRK; E0 -> EXT.
//      - Mapped make code -> process make, stay IDLE.
//      - Any other byte (AA, FA, unmapped) is ignored, stay IDLE.
//    * BRK: any byte -> IDLE. If it maps to the held key's ASCII and key_held=1,
//      process release; otherwise ignore.
//    * EXT: F0 -> EXT_BRK; any other byte is discarded -> IDLE.
//    * EXT_BRK: any byte is discarded -> IDLE.
//  - Process make:
//    * No key held, or a different key held: ascii_val<=mapped value, key_held<=1,
//      key_press<=1.
//    * A different key held: last-key priority. No key_release for the old key; its
//      later break is ignored.
//    * Same key already held (typematic repeat): no output change, no pulse.
//  - Process release: ascii_val<=7'h7F, key_held<=0, key_release<=1.
//  - Reset mid-sequence (e.g. after F0): returns to IDLE with reset values. The next
//    make code is processed normally.
// CONFIGURATION
//  - Macro AUTO_RELEASE_EN.
//  - When defined:
//    * A 25-bit counter clears on every ps2_byte_valid and while key_held=0.
//    * Otherwise it increments.
//    * When it reaches RELEASE_TIMEOUT-1 with key_held=1: process release and clear
//      the counter. The FSM state is unchanged.
//    * If a byte arrives in the timeout cycle, the byte wins and the counter clears.
//  - When not defined: no counter is synthesized. A key stays held until its break
//    code arrives.
// TESTING
//  - Reset, then bytes 1C: ascii_val=65, key_held=1, key_press high one cycle, one cycle
//    after the strobe.
//  - 1C,1C,1C (repeat): exactly one key_press; then F0,1C gives ascii_val=7F,
//    key_held=0, one key_release.
//  - 1C then 1D: ascii_val=87, second key_press, no key_release.
//    Then F0,1C: ignored (ascii_val stays 87). Then F0,1D: release.
//  - E0,75 and E0,F0,75 and AA, FA, 15: no output change, FSM back in IDLE.
//    Then 3B gives ascii_val=74.
//  - Assert reset after F0, then 24: ascii_val=69, key_press (not treated as a break).
//  - AUTO_RELEASE_EN with RELEASE_TIMEOUT=16: 23, then idle. key_release exactly
//    16 cycles after key_held rose, ascii_val=7F.
//    Without the macro: key_held stays 1 for 1000 cycles.

Source files
------------

// File: rtl/ps2_note_key_decoder.sv
// PS/2 scan-code stream to held-key ASCII; outputs registered one cycle after each strobe, no backpressure.
// Optional AUTO_RELEASE_EN adds an inactivity counter that force-releases a held key.
module ps2_note_key_decoder #(
  parameter int unsigned RELEASE_TIMEOUT = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic [6:0] ascii_val,
  output logic       key_held,
  output logic       key_press,
  output logic       key_release
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [6:0] NO_KEY = 7'h7F;

  state_t     state_q, state_d;
  logic [6:0] ascii_q, ascii_d;
  logic       held_q, held_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic [6:0] map_ascii;
  logic       map_hit;
  logic       timeout_hit;

  always_comb begin
    map_hit   = 1'b1;
    map_ascii = NO_KEY;
    case (ps2_byte)
      8'h1C: map_ascii = 7'd65;
      8'h1D: map_ascii = 7'd87;
      8'h1B: map_ascii = 7'd83;
      8'h24: map_ascii = 7'd69;
      8'h23: map_ascii = 7'd68;
      8'h2B: map_ascii = 7'd70;
      8'h2C: map_ascii = 7'd84;
      8'h34: map_ascii = 7'd71;
      8'h35: map_ascii = 7'd89;
      8'h33: map_ascii = 7'd72;
      8'h3C: map_ascii = 7'd85;
      8'h3B: map_ascii = 7'd74;
      default: map_hit = 1'b0;
    endcase
  end

`ifdef AUTO_RELEASE_EN
  localparam logic [24:0] TIMEOUT_LAST = 25'(RELEASE_TIMEOUT - 1);

  logic [24:0] cnt_q, cnt_d;

  assign timeout_hit = held_q && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    if (ps2_byte_valid || !held_q || timeout_hit) cnt_d = '0;
    else                                          cnt_d = cnt_q + 25'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // No counter in this build: a held key is only released by its break code.
  assign timeout_hit = 1'b0 && (RELEASE_TIMEOUT != 0);
`endif

  always_comb begin
    state_d   = state_q;
    ascii_d   = ascii_q;
    held_d    = held_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (ps2_byte_valid) begin
      case (state_q)
        IDLE: begin
          if (ps2_byte == 8'hF0)      state_d = BRK;
          else if (ps2_byte == 8'hE0) state_d = EXT;
          else if (map_hit && !(held_q && ascii_q == map_ascii)) begin
            // Last-key priority: a new make silently replaces the held key.
            ascii_d = map_ascii;
            held_d  = 1'b1;
            press_d = 1'b1;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (map_hit && held_q && map_ascii == ascii_q) begin
            ascii_d   = NO_KEY;
            held_d    = 1'b0;
            release_d = 1'b1;
          end
        end
        EXT:     state_d = (ps2_byte == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      ascii_d   = NO_KEY;
      held_d    = 1'b0;
      release_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ascii_q   <= NO_KEY;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ascii_q   <= ascii_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign ascii_val   = ascii_q;
  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_ps2_note_key_decoder.sv
// Bench for ps2_note_key_decoder: directed table, reset/timeout sequences, randomized run vs. prefix model.
module tb_ps2_note_key_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic [6:0] ascii_val;
  logic       key_held;
  logic       key_press;
  logic       key_release;

  always #5 clk = ~clk;

`ifdef AUTO_RELEASE_EN
  ps2_note_key_decoder #(.RELEASE_TIMEOUT(16)) dut (
`else
  ps2_note_key_decoder dut (
`endif
    .clk(clk), .reset(reset), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
    .ascii_val(ascii_val), .key_held(key_held), .key_press(key_press), .key_release(key_release));

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] key_codes [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                 8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
  logic [6:0] key_chars [12] = '{"A", "W", "S", "E", "D", "F", "T", "G", "Y", "H", "U", "J"};

  // Reference model: pending-prefix flags plus the currently held character.
  logic [6:0] m_ascii;
  logic       m_held, m_press, m_rel, m_brk, m_ext;

  function automatic void lookup(input logic [7:0] b, output logic hit, output logic [6:0] a);
    hit = 1'b0;
    a   = 7'h7F;
    for (int i = 0; i < 12; i++)
      if (key_codes[i] == b) begin
        hit = 1'b1;
        a   = key_chars[i];
      end
  endfunction

  function void model_reset();
    m_ascii = 7'h7F; m_held = 0; m_press = 0; m_rel = 0; m_brk = 0; m_ext = 0;
  endfunction

  function void model_step(input logic v, input logic [7:0] b);
    logic       hit;
    logic [6:0] a;
    m_press = 0;
    m_rel   = 0;
    if (v) begin
      lookup(b, hit, a);
      if (m_ext) begin
        if (!m_brk && b == 8'hF0) m_brk = 1;
        else begin m_brk = 0; m_ext = 0; end
      end else if (m_brk) begin
        m_brk = 0;
        if (hit && m_held && a == m_ascii) begin
          m_ascii = 7'h7F; m_held = 0; m_rel = 1;
        end
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (hit && !(m_held && a == m_ascii)) begin
        m_ascii = a; m_held = 1; m_press = 1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] a, input logic h, input logic p, input logic r);
    chk({tag, ".ascii"}, 32'(ascii_val), 32'(a));
    chk({tag, ".held"}, 32'(key_held), 32'(h));
    chk({tag, ".press"}, 32'(key_press), 32'(p));
    chk({tag, ".release"}, 32'(key_release), 32'(r));
  endtask

  task automatic apply(input logic v, input logic [7:0] b);
    ps2_byte_valid = v;
    ps2_byte       = b;
    @(posedge clk);
    #1;
    ps2_byte_valid = 1'b0;
    model_step(v, b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ps2_byte_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic [6:0] a;
    logic       h, p, r;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int rel_at;
    int hold_cnt;
    logic [7:0] extra [4];
    extra = '{8'hAA, 8'hFA, 8'h15, 8'h75};

    tbl.push_back('{1, 8'h1C, 7'h41, 1, 1, 0});
    tbl.push_back('{0, 8'h00, 7'h41, 1, 0, 0});
    tbl.push_back('{1, 8'h1C, 7'h41, 1, 0, 0});
    tbl.push_back('{1, 8'h1C, 7'h41, 1, 0, 0});
    tbl.push_back('{1, 8'hF0, 7'h41, 1, 0, 0});
    tbl.push_back('{1, 8'h1C, 7'h7F, 0, 0, 1});
    tbl.push_back('{0, 8'h00, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'h1C, 7'h41, 1, 1, 0});
    tbl.push_back('{1, 8'h1D, 7'h57, 1, 1, 0});
    tbl.push_back('{1, 8'hF0, 7'h57, 1, 0, 0});
    tbl.push_back('{1, 8'h1C, 7'h57, 1, 0, 0});
    tbl.push_back('{1, 8'hF0, 7'h57, 1, 0, 0});
    tbl.push_back('{1, 8'h1D, 7'h7F, 0, 0, 1});
    tbl.push_back('{1, 8'hE0, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'h75, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'hE0, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'hF0, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'h75, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'hAA, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'hFA, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'h15, 7'h7F, 0, 0, 0});
    tbl.push_back('{1, 8'h3B, 7'h4A, 1, 1, 0});
    tbl.push_back('{1, 8'hE0, 7'h4A, 1, 0, 0});
    tbl.push_back('{1, 8'h1C, 7'h4A, 1, 0, 0});
    tbl.push_back('{1, 8'hF0, 7'h4A, 1, 0, 0});
    tbl.push_back('{1, 8'h3B, 7'h7F, 0, 0, 1});
    tbl.push_back('{1, 8'h24, 7'h45, 1, 1, 0});
    tbl.push_back('{1, 8'hE0, 7'h45, 1, 0, 0});
    tbl.push_back('{1, 8'hF0, 7'h45, 1, 0, 0});
    tbl.push_back('{1, 8'h24, 7'h45, 1, 0, 0});

    reset = 1'b1;
    ps2_byte_valid = 1'b0;
    ps2_byte = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 7'h7F, 0, 0, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].b);
      chk_all($sformatf("tbl%0d", i), tbl[i].a, tbl[i].h, tbl[i].p, tbl[i].r);
    end

    // Reset arriving between F0 and its key must not turn the next make into a break.
    do_reset();
    apply(1, 8'h1D);
    apply(1, 8'hF0);
    reset = 1'b1;
    #2;
    chk_all("midreset", 7'h7F, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    apply(1, 8'h24);
    chk_all("after_midreset", 7'h45, 1, 1, 0);

    for (int i = 0; i < 600; i++) begin
      int gap;
      int sel;
      logic [7:0] b;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        apply(0, 8'h00);
        chk_all("rnd_idle", m_ascii, m_held, m_press, m_rel);
      end
      sel = $urandom_range(0, 9);
      if (sel <= 4)      b = key_codes[$urandom_range(0, 11)];
      else if (sel <= 6) b = 8'hF0;
      else if (sel == 7) b = 8'hE0;
      else if (sel == 8) b = extra[$urandom_range(0, 3)];
      else               b = 8'($urandom);
      apply(1, b);
      chk_all($sformatf("rnd_byte_%0h", b), m_ascii, m_held, m_press, m_rel);
    end

    do_reset();
    apply(1, 8'h23);
    chk_all("timeout_make", 7'h44, 1, 1, 0);
`ifdef AUTO_RELEASE_EN
    rel_at = -1;
    for (int i = 1; i <= 100; i++) begin
      apply(0, 8'h00);
      if (key_release === 1'b1) begin
        rel_at = i;
        break;
      end
    end
    chk("timeout_cycles", 32'(rel_at), 32'd16);
    chk("timeout_ascii", 32'(ascii_val), 32'h7F);
    chk("timeout_held", 32'(key_held), 32'd0);
`else
    hold_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      apply(0, 8'h00);
      if (key_held === 1'b1 && ascii_val === 7'h44 && key_release === 1'b0) hold_cnt++;
    end
    chk("hold_1000", 32'(hold_cnt), 32'd1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
